// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-prediction fetch controller.
package bp_pkg;

  localparam logic [31:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_next_pc;
  } pred_entry_t;

  // Next PC: either the supplied target or the sequential successor.
  function automatic logic [31:0] next_pc(input logic        take,
                                          input logic [31:0] target,
                                          input logic [31:0] pc);
    return take ? target : pc + PC_INCR;
  endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// Prediction queue: one entry per in-flight fetch, oldest at head.
// Head is read combinationally so execute can compare in the same cycle.
// Clear wins over push; push is accepted when full only alongside a pop.
module bp_pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t push_data,
  output logic        full,
  output logic        empty,
  output pred_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  pred_entry_t        mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_reg[rd_ptr_reg];

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointers and occupancy; pointer wrap relies on DEPTH being a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/bp_fetch_ctrl.sv
// Fetch PC controller with branch-prediction queue and mispredict redirect.
// Optional statistics counters enabled by defining BP_FETCH_CTRL_STATS_EN.
module bp_fetch_ctrl
  import bp_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_stall,
  input  logic        bp_predicted_en,
  input  logic        bp_predicted_taken_en,
  input  logic [31:0] bp_predicted_pc,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_branch_en,
  input  logic        e_branch_taken_en,
  input  logic [31:0] e_branch_target,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        e_mispredict_en,
  output logic        flush,
  output logic        q_full,
  output logic        seq_err,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  f_pc_reg;
  logic         seq_err_reg;
  logic [31:0]  pred_next_pc;
  logic [31:0]  actual_next_pc;
  logic         deq_valid;
  logic         mispredict;
  logic         push;
  logic         q_empty;
  pred_entry_t  q_head;
  pred_entry_t  push_data;

  assign pred_next_pc   = next_pc(bp_predicted_en && bp_predicted_taken_en,
                                  bp_predicted_pc, f_pc_reg);
  assign actual_next_pc = next_pc(e_branch_en && e_branch_taken_en,
                                  e_branch_target, e_pc);
  assign deq_valid      = e_valid && !q_empty;
  assign mispredict     = deq_valid && (actual_next_pc != q_head.pred_next_pc);
  assign f_valid        = (state_reg == ST_RUN) && !q_full;
  assign push           = f_valid && !f_stall && !mispredict;

  assign push_data.pc           = f_pc_reg;
  assign push_data.pred_next_pc = pred_next_pc;

  assign f_pc            = f_pc_reg;
  assign e_mispredict_en = mispredict;
  assign flush           = mispredict;
  assign seq_err         = seq_err_reg;

  bp_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (deq_valid),
    .clear     (mispredict),
    .push_data (push_data),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // FSM next state: a mispredict always forces a one-cycle redirect bubble.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     state_next = ST_RUN;
      ST_RUN:      state_next = mispredict ? ST_REDIRECT : ST_RUN;
      ST_REDIRECT: state_next = ST_RUN;
      default:     state_next = ST_IDLE;
    endcase
    if (mispredict) state_next = ST_REDIRECT;
  end

  // Fetch PC: redirect on mispredict, advance on accepted fetch, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        f_pc_reg <= RESET_PC;
    else if (mispredict) f_pc_reg <= actual_next_pc;
    else if (push)       f_pc_reg <= pred_next_pc;
  end

  // Sticky retire-ordering error: retire with nothing queued or wrong PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      seq_err_reg <= 1'b0;
    else if (e_valid && (q_empty || (e_pc != q_head.pc)))
      seq_err_reg <= 1'b1;
  end

`ifdef BP_FETCH_CTRL_STATS_EN
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispredicts_reg;

  // Saturating counters of retired branches and mispredicts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (deq_valid && e_branch_en && (stat_branches_reg != 32'hFFFF_FFFF))
        stat_branches_reg <= stat_branches_reg + 32'd1;
      if (mispredict && (stat_mispredicts_reg != 32'hFFFF_FFFF))
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: doc/bp_fetch_ctrl.md
BP_FETCH_CTRL -- requirements
Module: bp_fetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 4, prediction-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port f_stall  in  1  fetch stage cannot accept a PC this cycle.
REQ-006 SHALL have port bp_predicted_en  in  1  predictor hit for f_pc.
REQ-007 SHALL have port bp_predicted_taken_en  in  1  predicted direction, valid when bp_predicted_en=1.
REQ-008 SHALL have port bp_predicted_pc  in  32  predicted target, valid when bp_predicted_en=1.
REQ-009 SHALL have port e_valid  in  1  execute retires one instruction this cycle.
REQ-010 SHALL have port e_pc  in  32  PC of retiring instruction.
REQ-011 SHALL have port e_branch_en  in  1  retiring instruction is a branch.
REQ-012 SHALL have port e_branch_taken_en  in  1  branch resolved taken.
REQ-013 SHALL have port e_branch_target  in  32  resolved branch target.
REQ-014 SHALL have port f_pc  out  32  current fetch PC (also drives predictor lookup).
REQ-015 SHALL have port f_valid  out  1  f_pc is a real fetch this cycle.
REQ-016 SHALL have port e_mispredict_en  out  1  retiring instruction was mispredicted.
REQ-017 SHALL have port flush  out  1  kill all younger in-flight instructions.
REQ-018 SHALL have port q_full  out  1  prediction queue full.
REQ-019 SHALL have port seq_err  out  1  sticky: e_valid with empty queue or e_pc != head PC.
REQ-020 SHALL have ports stat_branches, stat_mispredicts  out  32 each  statistics counters (REQ-032).

Function
REQ-021 SHALL compute predicted next PC: bp_predicted_en && bp_predicted_taken_en ? bp_predicted_pc : f_pc+4 (32-bit wrap).
REQ-022 SHALL implement FSM IDLE -> RUN (unconditional, one cycle), RUN -> REDIRECT on mispredict, REDIRECT -> RUN after one cycle.
REQ-023 SHALL drive f_valid=1 only in RUN with q_full=0; IDLE and REDIRECT drive f_valid=0.
REQ-024 SHALL, when f_valid && !f_stall && no mispredict this cycle, enqueue {f_pc, predicted next PC} and load f_pc with predicted next PC; otherwise hold f_pc.
REQ-025 SHALL, on e_valid with non-empty queue, dequeue head and compute actual next PC: e_branch_en && e_branch_taken_en ? e_branch_target : e_pc+4.
REQ-026 SHALL assert e_mispredict_en combinationally in the same cycle when actual next PC != head predicted next PC.
REQ-027 SHALL, on mispredict, assert flush for that cycle, empty the queue (including any same-cycle enqueue), load f_pc with actual next PC, enter REDIRECT.
REQ-028 SHALL permit simultaneous enqueue and dequeue, including when full at cycle start (count unchanged); q_full = count==DEPTH.
REQ-029 SHALL ignore e_valid with empty queue (no dequeue, no mispredict) and set seq_err; seq_err also set on e_pc != head PC, cleared only by reset.

Reset
REQ-030 SHALL, while reset_n=0, force: f_pc=RESET_PC, FSM=IDLE, queue empty, f_valid=0, e_mispredict_en=0, flush=0, q_full=0, seq_err=0, stat counters=0.
REQ-031 SHALL discard all in-flight queue contents on reset assertion mid-operation; first f_valid=1 occurs second rising edge after deassertion.

Configuration
REQ-032 SHALL, with BP_FETCH_CTRL_STATS_EN defined, count dequeued branches (e_branch_en) in stat_branches and mispredicts in stat_mispredicts, saturating at 32'hFFFF_FFFF; without it, both outputs SHALL be constant 0 and no counter flops exist.

Structure
REQ-033 SHALL place FSM state enum, queue entry struct {pc, pred_next_pc}, and PC_INCR=4 in shared package bp_pkg.
REQ-034 SHALL implement the queue as sub-module bp_pred_fifo (push, pop, clear, full, empty, head), clear priority over push.

Verification
REQ-035 Reset release, no stalls, predictor miss -> f_pc 0x0,0x4,0x8 on consecutive RUN cycles, f_valid=0 first cycle.
REQ-036 Predictor hit at 0x8, taken, target 0x40 -> next f_pc=0x40; execute retires 0x8 taken to 0x40 -> e_mispredict_en=0.
REQ-037 Same as 036 but execute resolves not-taken -> e_mispredict_en=1, flush=1, next f_pc=0xC, one f_valid=0 cycle, queue empty.
REQ-038 DEPTH=4, e_valid held 0 -> q_full=1 after four fetches, f_valid=0; one e_valid -> fetch resumes next cycle.
REQ-039 e_valid with empty queue -> seq_err=1, no flush; stays 1 until reset_n=0.
REQ-040 With BP_FETCH_CTRL_STATS_EN: 3 branches, 1 mispredict retired -> stat_branches=3, stat_mispredicts=1; without macro both 0.
